bsg_manycore_ruche_x_link_edge_responder: RTL and testbench

// Active termination for a ruche X link at the array edge, used where the link is not left idle.

---
 rtl/bsg_manycore_ruche_x_link_edge_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_bsg_manycore_ruche_x_link_edge_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_ruche_x_link_edge_responder.sv
// bsg_manycore_ruche_x_link_edge_responder
//
// Active termination for a ruche X link at the edge of the manycore array.
// The link from the array may carry a stage-dependent polarity inversion.
// This block removes that inversion on the way in and applies it again on the
// way out. Incoming request (fwd) packets are queued in a small FIFO. Each
// request gets a response (rev) packet, so that a sender that targets the edge
// by mistake is never left waiting. Errant traffic in both directions is
// counted and latched into a sticky error flag.
//
// Link layout, MSB first:
//   ruche_link = {fwd_link, rev_link}
//   *_link     = {v, ready_and_rev, packet}
//   fwd packet = {addr, op[3:0], reg_id[4:0], payload, src_y, src_x, y_cord, x_cord}
//   rev packet = {pkt_type[1:0], data, reg_id[4:0], y_cord, x_cord}
//   op 0 = remote load. pkt_type 0 = credit, 1 = int writeback.
//
// Ports:
//   clk_i         clock
//   reset_i       synchronous, active-high reset
//   ruche_link_i  link from the array (possibly inverted)
//   ruche_link_o  link to the array (inversion applied)
//   fwd_count_o   saturating count of accepted fwd packets
//   rev_count_o   saturating count of errant rev packets received
//   error_o       sticky flag, set by any accepted fwd or received rev packet
module bsg_manycore_ruche_x_link_edge_responder #(
  parameter int addr_width_p     = 8,
  parameter int data_width_p     = 8,
  parameter int x_cord_width_p   = 3,
  parameter int y_cord_width_p   = 2,
  parameter int ruche_factor_X_p = 2,
  parameter int ruche_stage_p    = 1,
  parameter int west_not_east_p  = 1,
  parameter int fifo_els_p       = 2,
  parameter int count_width_p    = 16,
  localparam int fwd_pkt_width_lp = addr_width_p + 4 + 5 + data_width_p
                                    + 2*x_cord_width_p + 2*y_cord_width_p,
  localparam int ret_pkt_width_lp = 2 + data_width_p + 5 + x_cord_width_p + y_cord_width_p,
  localparam int link_width_lp    = fwd_pkt_width_lp + ret_pkt_width_lp + 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [link_width_lp-1:0] ruche_link_i,
  output logic [link_width_lp-1:0] ruche_link_o,
  output logic [count_width_p-1:0] fwd_count_o,
  output logic [count_width_p-1:0] rev_count_o,
  output logic                     error_o
);

  localparam int x_w_lp = x_cord_width_p;
  localparam int y_w_lp = y_cord_width_p;

  // fwd packet field offsets
  localparam int src_x_lsb_lp   = x_w_lp + y_w_lp;
  localparam int src_y_lsb_lp   = 2*x_w_lp + y_w_lp;
  localparam int payload_lsb_lp = 2*x_w_lp + 2*y_w_lp;
  localparam int reg_id_lsb_lp  = payload_lsb_lp + data_width_p;
  localparam int op_lsb_lp      = reg_id_lsb_lp + 5;
  localparam int addr_lsb_lp    = op_lsb_lp + 4;

  localparam int rev_link_width_lp = ret_pkt_width_lp + 2;

  localparam logic [3:0] op_load_lp      = 4'd0;
  localparam logic [1:0] ret_credit_lp   = 2'd0;
  localparam logic [1:0] ret_int_wb_lp   = 2'd1;

  // Polarity of this edge. Odd ruche factors alternate the inversion phase
  // between the west and east ends of the same stage.
  localparam bit factor_even_lp = (ruche_factor_X_p % 2) == 0;
  localparam bit stage_odd_lp   = (ruche_stage_p % 2) == 1;
  localparam bit west_lp        = west_not_east_p != 0;
  localparam bit invert_out_lp  = (ruche_stage_p > 0) &&
    (factor_even_lp ? stage_odd_lp : (west_lp ? !stage_odd_lp : stage_odd_lp));
  localparam bit invert_in_lp   = (ruche_stage_p > 0) &&
    (factor_even_lp ? stage_odd_lp : (west_lp ? stage_odd_lp : !stage_odd_lp));

  localparam int ptr_width_lp = $clog2(fifo_els_p);
  localparam int cnt_width_lp = $clog2(fifo_els_p + 1);
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(fifo_els_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_full_lp = cnt_width_lp'(fifo_els_p);

  // Only the fields needed to build the response are stored.
  typedef struct packed {
    logic              is_load;
    logic [4:0]        reg_id;
    logic [y_w_lp-1:0] src_y;
    logic [x_w_lp-1:0] src_x;
  } entry_s;

  typedef enum logic {e_idle, e_resp} state_e;

  // -------------------------------------------------------------------------
  // Input de-inversion and field decode
  // -------------------------------------------------------------------------
  logic [link_width_lp-1:0]    link_in;
  logic [fwd_pkt_width_lp-1:0] in_fwd_pkt;
  logic                        in_fwd_v;
  logic                        in_rev_v;
  logic                        in_rev_ready;
  entry_s                      in_entry;

  assign link_in      = ruche_link_i ^ {link_width_lp{invert_in_lp}};
  assign in_fwd_v     = link_in[link_width_lp-1];
  assign in_fwd_pkt   = link_in[rev_link_width_lp +: fwd_pkt_width_lp];
  assign in_rev_v     = link_in[rev_link_width_lp-1];
  assign in_rev_ready = link_in[ret_pkt_width_lp];

  assign in_entry = {in_fwd_pkt[op_lsb_lp +: 4] == op_load_lp,
                     in_fwd_pkt[reg_id_lsb_lp +: 5],
                     in_fwd_pkt[src_y_lsb_lp +: y_w_lp],
                     in_fwd_pkt[src_x_lsb_lp +: x_w_lp]};

  // Fields that a terminating edge has no use for.
  logic unused_bits;
  assign unused_bits = ^{link_in[link_width_lp-2],
                         link_in[ret_pkt_width_lp-1:0],
                         in_fwd_pkt[fwd_pkt_width_lp-1:addr_lsb_lp],
                         in_fwd_pkt[reg_id_lsb_lp-1:payload_lsb_lp],
                         in_fwd_pkt[src_x_lsb_lp-1:0]};

  // -------------------------------------------------------------------------
  // Request FIFO and response FSM
  // -------------------------------------------------------------------------
  entry_s                  fifo_mem [fifo_els_p];
  logic [ptr_width_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [cnt_width_lp-1:0] fifo_cnt_r;
  logic                    fifo_full, fifo_empty;

  state_e state_r, state_n;
  entry_s resp_r, resp_n;
  logic   resp_load;
  logic   accept, rev_fire, load_slot, enq, deq;

  assign fifo_full  = (fifo_cnt_r == cnt_full_lp);
  assign fifo_empty = (fifo_cnt_r == '0);

  // Ready depends on full only, so a full FIFO never sees enqueue and
  // dequeue in the same cycle.
  assign accept   = in_fwd_v & ~fifo_full & ~reset_i;
  assign rev_fire = (state_r == e_resp) & in_rev_ready;

  // The response register can take a new packet when it is empty or when
  // its current packet is leaving this cycle.
  assign load_slot = (state_r == e_idle) | rev_fire;
  assign deq       = load_slot & ~fifo_empty;
  // With an empty FIFO a fresh request bypasses straight into the response
  // register, giving a one-cycle turnaround and keeping order intact.
  assign enq       = accept & ~(load_slot & fifo_empty);

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // NOTE: always_comb gives every output a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n   = state_r;
    resp_n    = resp_r;
    resp_load = 1'b0;
    if (load_slot) begin
      if (deq) begin
        resp_load = 1'b1;
        resp_n    = fifo_mem[rd_ptr_r];
        state_n   = e_resp;
      end else if (accept) begin
        resp_load = 1'b1;
        resp_n    = in_entry;
        state_n   = e_resp;
      end else begin
        state_n   = e_idle;
      end
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count decide which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_mem[wr_ptr_r] <= in_entry;
    end
  end

  logic [count_width_p-1:0] fwd_count_r, rev_count_r;
  logic                     error_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      resp_r      <= '0;
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      fifo_cnt_r  <= '0;
      fwd_count_r <= '0;
      rev_count_r <= '0;
      error_r     <= 1'b0;
    end else begin
      state_r <= state_n;
      if (resp_load) begin
        resp_r <= resp_n;
      end
      if (enq) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (deq) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({enq, deq})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + cnt_width_lp'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - cnt_width_lp'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      // Saturating debug counters.
      if (accept && (fwd_count_r != {count_width_p{1'b1}})) begin
        fwd_count_r <= fwd_count_r + count_width_p'(1);
      end
      if (in_rev_v && (rev_count_r != {count_width_p{1'b1}})) begin
        rev_count_r <= rev_count_r + count_width_p'(1);
      end
      if (accept || in_rev_v) begin
        error_r <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output assembly and re-inversion
  // -------------------------------------------------------------------------
  logic                         out_fwd_ready, out_rev_v, out_rev_ready;
  logic [ret_pkt_width_lp-1:0]  ret_pkt;

  // Every logical output field is held at 0 while reset is asserted.
  assign out_fwd_ready = ~fifo_full & ~reset_i;
  assign out_rev_ready = ~reset_i;
  assign out_rev_v     = (state_r == e_resp) & ~reset_i;
  assign ret_pkt       = out_rev_v
                         ? {(resp_r.is_load ? ret_int_wb_lp : ret_credit_lp),
                            {data_width_p{1'b0}},
                            resp_r.reg_id, resp_r.src_y, resp_r.src_x}
                         : '0;

  assign ruche_link_o = {1'b0, out_fwd_ready, {fwd_pkt_width_lp{1'b0}},
                         out_rev_v, out_rev_ready, ret_pkt}
                        ^ {link_width_lp{invert_out_lp}};

  assign fwd_count_o = fwd_count_r;
  assign rev_count_o = rev_count_r;
  assign error_o     = error_r;

endmodule

// File: tb/tb_bsg_manycore_ruche_x_link_edge_responder.sv
// Testbench for bsg_manycore_ruche_x_link_edge_responder.
// A main instance is checked every cycle against a queue-based model of
// outstanding requests. A second instance with 2-bit counters shares its
// inputs and shows saturation. Four more instances sit idle to show the
// polarity of each edge configuration.
module tb_bsg_manycore_ruche_x_link_edge_responder;

  localparam int AW = 8, DW = 8, XW = 3, YW = 2;
  localparam int FACTOR = 2, STAGE = 1, WEST = 1;
  localparam int ELS = 2, CW = 16, SAT_CW = 2;

  localparam int FWD_PKT_W  = AW + 4 + 5 + DW + 2*XW + 2*YW;
  localparam int RET_W      = 2 + DW + 5 + XW + YW;
  localparam int REV_LINK_W = RET_W + 2;
  localparam int LINK_W     = FWD_PKT_W + RET_W + 4;

  function automatic bit f_inv_out(input int f, input int s, input int w);
    if (s == 0) return 1'b0;
    if (f % 2 == 0) return (s % 2) == 1;
    return (w != 0) ? ((s % 2) == 0) : ((s % 2) == 1);
  endfunction

  function automatic bit f_inv_in(input int f, input int s, input int w);
    if (s == 0) return 1'b0;
    if (f % 2 == 0) return (s % 2) == 1;
    return (w != 0) ? ((s % 2) == 1) : ((s % 2) == 0);
  endfunction

  localparam bit INV_OUT = f_inv_out(FACTOR, STAGE, WEST);
  localparam bit INV_IN  = f_inv_in(FACTOR, STAGE, WEST);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    op;
    logic [4:0]    reg_id;
    logic [DW-1:0] payload;
    logic [YW-1:0] src_y;
    logic [XW-1:0] src_x;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
  } req_t;

  // What the requester expects back.
  typedef struct packed {
    logic          is_load;
    logic [4:0]    reg_id;
    logic [YW-1:0] y;
    logic [XW-1:0] x;
  } ret_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              drv_fwd_v, drv_fwd_rdy, drv_rev_v, drv_rev_ready;
  req_t              drv_req;
  logic [RET_W-1:0]  drv_rev_data;
  logic [LINK_W-1:0] link_i, link_o, sat_link_o;
  logic [CW-1:0]     fwd_cnt, rev_cnt;
  logic [SAT_CW-1:0] sat_fwd_cnt, sat_rev_cnt;
  logic              err, sat_err;

  assign link_i = {drv_fwd_v, drv_fwd_rdy, drv_req, drv_rev_v, drv_rev_ready, drv_rev_data}
                  ^ {LINK_W{INV_IN}};

  bsg_manycore_ruche_x_link_edge_responder #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .ruche_factor_X_p(FACTOR), .ruche_stage_p(STAGE), .west_not_east_p(WEST),
    .fifo_els_p(ELS), .count_width_p(CW)
  ) u_dut (
    .clk_i(clk), .reset_i(reset), .ruche_link_i(link_i), .ruche_link_o(link_o),
    .fwd_count_o(fwd_cnt), .rev_count_o(rev_cnt), .error_o(err)
  );

  bsg_manycore_ruche_x_link_edge_responder #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .ruche_factor_X_p(FACTOR), .ruche_stage_p(STAGE), .west_not_east_p(WEST),
    .fifo_els_p(ELS), .count_width_p(SAT_CW)
  ) u_sat (
    .clk_i(clk), .reset_i(reset), .ruche_link_i(link_i), .ruche_link_o(sat_link_o),
    .fwd_count_o(sat_fwd_cnt), .rev_count_o(sat_rev_cnt), .error_o(sat_err)
  );

  // Polarity instances: k=0/1 factor 2 stage 1 west/east, k=2/3 factor 3 stage 2 west/east.
  logic [LINK_W-1:0] pol_in  [4];
  logic [LINK_W-1:0] pol_out [4];
  logic [CW-1:0]     pol_fcnt[4];
  logic [CW-1:0]     pol_rcnt[4];
  logic              pol_err [4];

  for (genvar k = 0; k < 4; k++) begin : g_pol
    localparam int PF = (k < 2) ? 2 : 3;
    localparam int PS = (k < 2) ? 1 : 2;
    localparam int PW = (k % 2 == 0) ? 1 : 0;
    // Logical all-zero (idle) input, in the polarity this edge receives.
    assign pol_in[k] = {LINK_W{f_inv_in(PF, PS, PW)}};
    bsg_manycore_ruche_x_link_edge_responder #(
      .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
      .ruche_factor_X_p(PF), .ruche_stage_p(PS), .west_not_east_p(PW),
      .fifo_els_p(ELS), .count_width_p(CW)
    ) u_pol (
      .clk_i(clk), .reset_i(reset), .ruche_link_i(pol_in[k]), .ruche_link_o(pol_out[k]),
      .fwd_count_o(pol_fcnt[k]), .rev_count_o(pol_rcnt[k]), .error_o(pol_err[k])
    );
  end

  // Logical view of the main instance's output.
  logic [LINK_W-1:0] main_logical;
  logic              obs_fwd_ready, obs_rev_v;
  logic [RET_W-1:0]  obs_ret;
  assign main_logical  = link_o ^ {LINK_W{INV_OUT}};
  assign obs_fwd_ready = main_logical[LINK_W-2];
  assign obs_rev_v     = main_logical[REV_LINK_W-1];
  assign obs_ret       = main_logical[RET_W-1:0];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   fire_cnt, first_fire_cyc, last_fire_cyc;

  // Reference model: outstanding requests in arrival order, plus plain counts.
  ret_t m_q[$];
  int   m_fwd, m_rev;
  bit   m_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RET_W-1:0] pack_ret(input ret_t r);
    return {(r.is_load ? 2'd1 : 2'd0), {DW{1'b0}}, r.reg_id, r.y, r.x};
  endfunction

  function automatic ret_t to_ret(input req_t q);
    ret_t r;
    r.is_load = (q.op == 4'd0);
    r.reg_id  = q.reg_id;
    r.y       = q.src_y;
    r.x       = q.src_x;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t q;
    q = req_t'({$urandom, $urandom});
    return q;
  endfunction

  // One clock: compare every output to the model mid-cycle, then advance the
  // model by what happens at the coming edge.
  task automatic tick();
    int               occ;
    bit               exp_frdy, exp_rv;
    logic [RET_W-1:0] exp_ret;
    logic [LINK_W-1:0] exp_link;
    int               sat_exp;
    @(negedge clk);
    occ      = m_q.size();
    exp_frdy = !reset && (occ <= ELS);
    exp_rv   = !reset && (occ > 0);
    exp_ret  = '0;
    if (exp_rv) exp_ret = pack_ret(m_q[0]);
    exp_link = {1'b0, exp_frdy, {FWD_PKT_W{1'b0}}, exp_rv, !reset, exp_ret}
               ^ {LINK_W{INV_OUT}};
    check("link_o", link_o, exp_link);
    check("sat_link_o", sat_link_o, exp_link);
    check("fwd_count", fwd_cnt, m_fwd);
    check("rev_count", rev_cnt, m_rev);
    check("error", err, m_err);
    sat_exp = (m_fwd > 3) ? 3 : m_fwd;
    check("sat_fwd_count", sat_fwd_cnt, sat_exp);
    sat_exp = (m_rev > 3) ? 3 : m_rev;
    check("sat_rev_count", sat_rev_cnt, sat_exp);
    if (obs_rev_v && drv_rev_ready) begin
      fire_cnt++;
      if (fire_cnt == 1) first_fire_cyc = cyc;
      last_fire_cyc = cyc;
    end
    if (reset) begin
      m_q.delete();
      m_fwd = 0;
      m_rev = 0;
      m_err = 1'b0;
    end else begin
      if (exp_rv && drv_rev_ready) void'(m_q.pop_front());
      if (drv_fwd_v && exp_frdy) begin
        m_q.push_back(to_ret(drv_req));
        m_fwd++;
        m_err = 1'b1;
      end
      if (drv_rev_v) begin
        m_rev++;
        m_err = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    drv_fwd_v = 1'b0;
    drv_rev_v = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit   inv_k;
    req_t q;
    m_fwd = 0; m_rev = 0; m_err = 1'b0;
    fire_cnt = 0; first_fire_cyc = 0; last_fire_cyc = 0;
    reset         = 1'b1;
    drv_fwd_v     = 1'b0;
    drv_fwd_rdy   = 1'b0;
    drv_rev_v     = 1'b0;
    drv_rev_ready = 1'b0;
    drv_req       = '0;
    drv_rev_data  = '0;
    @(posedge clk);
    #1;

    // Polarity in reset: every logical field is 0, so the link shows the raw inversion.
    check("main_reset_link", link_o, {LINK_W{1'b1}});
    for (int k = 0; k < 4; k++) begin
      inv_k = f_inv_out((k < 2) ? 2 : 3, (k < 2) ? 1 : 2, (k % 2 == 0) ? 1 : 0);
      check($sformatf("pol%0d_reset_link", k), pol_out[k], {LINK_W{inv_k}});
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    // Out of reset with idle inputs: only the two ready bits are set.
    for (int k = 0; k < 4; k++) begin
      inv_k = f_inv_out((k < 2) ? 2 : 3, (k < 2) ? 1 : 2, (k % 2 == 0) ? 1 : 0);
      check($sformatf("pol%0d_idle_link", k), pol_out[k],
            {1'b0, 1'b1, {FWD_PKT_W{1'b0}}, 1'b0, 1'b1, {RET_W{1'b0}}} ^ {LINK_W{inv_k}});
      check($sformatf("pol%0d_fwd_count", k), pol_fcnt[k], 0);
      check($sformatf("pol%0d_rev_count", k), pol_rcnt[k], 0);
      check($sformatf("pol%0d_error", k), pol_err[k], 1'b0);
    end

    // Single load from (x3,y2), reg_id 5.
    q        = rand_req();
    q.op     = 4'd0;
    q.src_x  = 3'd3;
    q.src_y  = 2'd2;
    q.reg_id = 5'd5;
    drv_req       = q;
    drv_fwd_v     = 1'b1;
    drv_rev_ready = 1'b1;
    tick();
    drv_fwd_v = 1'b0;
    #1;
    check("load_rev_v", obs_rev_v, 1'b1);
    check("load_x", obs_ret[XW-1:0], 3);
    check("load_y", obs_ret[XW +: YW], 2);
    check("load_reg_id", obs_ret[XW+YW +: 5], 5);
    check("load_type", obs_ret[RET_W-1 -: 2], 1);
    check("load_fwd_count", fwd_cnt, 1);
    check("load_error", err, 1'b1);
    tick();
    tick();
    check("load_rev_v_after", obs_rev_v, 1'b0);

    // Back-to-back stores with the receiver always ready.
    do_reset();
    drv_rev_ready = 1'b1;
    fire_cnt      = 0;
    for (int i = 0; i < 4; i++) begin
      q      = rand_req();
      q.op   = 4'd1;
      drv_req   = q;
      drv_fwd_v = 1'b1;
      tick();
    end
    drv_fwd_v = 1'b0;
    repeat (3) tick();
    check("b2b_responses", fire_cnt, 4);
    check("b2b_consecutive", last_fire_cyc - first_fire_cyc, 3);
    check("b2b_fwd_count", fwd_cnt, 4);

    // Backpressure: receiver not ready, three requests fill FIFO plus response slot.
    do_reset();
    drv_rev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv_req   = rand_req();
      drv_fwd_v = 1'b1;
      tick();
    end
    drv_req = rand_req();
    #1;
    check("bp_fwd_ready", obs_fwd_ready, 1'b0);
    check("bp_rev_v", obs_rev_v, 1'b1);
    repeat (3) tick();
    drv_fwd_v     = 1'b0;
    drv_rev_ready = 1'b1;
    fire_cnt      = 0;
    repeat (4) tick();
    check("bp_drained", fire_cnt, 3);
    check("bp_fwd_count", fwd_cnt, 3);

    // Errant rev traffic.
    do_reset();
    drv_rev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_rev_v    = 1'b1;
      drv_rev_data = RET_W'({$urandom});
      tick();
    end
    drv_rev_v = 1'b0;
    #1;
    check("errant_rev_count", rev_cnt, 3);
    check("errant_error", err, 1'b1);
    check("errant_no_rev_out", obs_rev_v, 1'b0);
    check("errant_fwd_count", fwd_cnt, 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drv_fwd_v     = ($urandom_range(0, 99) < 60);
      drv_fwd_rdy   = 1'($urandom);
      drv_req       = rand_req();
      drv_rev_v     = ($urandom_range(0, 99) < 10);
      drv_rev_data  = RET_W'({$urandom});
      drv_rev_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    drv_fwd_v = 1'b0;
    drv_rev_v = 1'b0;
    drv_rev_ready = 1'b1;
    repeat (4) tick();

    // Saturation of the 2-bit counter instance.
    do_reset();
    drv_rev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv_req   = rand_req();
      drv_fwd_v = 1'b1;
      tick();
    end
    drv_fwd_v = 1'b0;
    tick();
    check("sat_fwd_count_3", sat_fwd_cnt, 3);
    check("sat_main_fwd_count_5", fwd_cnt, 5);

    // Reset while a response is being presented.
    drv_rev_ready = 1'b0;
    q      = rand_req();
    q.op   = 4'd0;
    drv_req   = q;
    drv_fwd_v = 1'b1;
    tick();
    drv_fwd_v = 1'b0;
    drv_rev_v = 1'b1;
    #1;
    check("rst_mid_rev_v_before", obs_rev_v, 1'b1);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    drv_rev_v = 1'b0;
    #1;
    check("rst_mid_rev_v", obs_rev_v, 1'b0);
    check("rst_mid_fwd_ready", obs_fwd_ready, 1'b1);
    check("rst_mid_fwd_count", fwd_cnt, 0);
    check("rst_mid_rev_count", rev_cnt, 0);
    check("rst_mid_error", err, 1'b0);
    check("rst_mid_sat_fwd", sat_fwd_cnt, 0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
